lpif_dstrm_fmt: RTL

- Downstream formatter sitting directly upstream of the x16 f1 master transceiver top; drives its dstrm_state/protid/data/bstart/bvalid/valid inputs.
- Accepts LPIF-style flits from the adapter on an irdy/trdy handshake with registered trdy, and buffers them in a 2-entry skid FIFO.
- Derives the byte-valid mask from offset and length, and gates emission with a far-side credit counter.
- Tracks link online state, flushing on loss of tx_online.

---
 rtl/lpif_txrx_pkg.sv | 44 ++++
 rtl/lpif_dstrm_skid_fifo.sv | 50 +++++
 rtl/lpif_dstrm_fmt.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lpif_txrx_pkg.sv
// Shared constants, FSM state type and the buffered beat record for the LPIF
// downstream formatter.
package lpif_txrx_pkg;

  localparam int DATA_W = 512;
  localparam int BYTES  = DATA_W / 8;
  localparam int CRD_W  = 8;
  localparam int OFF_W  = 6;
  localparam int NB_W   = 7;

  typedef enum logic {
    OFFLINE = 1'b0,
    ONLINE  = 1'b1
  } fmt_state_e;

  typedef struct packed {
    logic [1:0]        protid;
    logic [OFF_W-1:0]  bstart;
    logic [BYTES-1:0]  bvalid;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Lanes off .. off+nb-1, clipped at the top lane.
  function automatic logic [BYTES-1:0] byte_mask(input logic [OFF_W-1:0] off,
                                                 input logic [NB_W-1:0]  nb);
    logic [BYTES-1:0] mask;
    logic [7:0]       lim;
    logic [7:0]       lane;
    lim = {2'b00, off} + {1'b0, nb};
    for (int i = 0; i < BYTES; i++) begin
      lane    = 8'(i);
      mask[i] = (lane >= {2'b00, off}) && (lane < lim);
    end
    return mask;
  endfunction

  function automatic logic fmt_bad(input logic [OFF_W-1:0] off,
                                   input logic [NB_W-1:0]  nb);
    logic [7:0] lim;
    lim = {2'b00, off} + {1'b0, nb};
    return (nb == '0) || (nb > 7'd64) || (lim > 8'd64);
  endfunction

endpackage

// File: rtl/lpif_dstrm_skid_fifo.sv
// Two-entry beat buffer between the adapter handshake and the credit-gated
// output register; flush empties it in one cycle.
module lpif_dstrm_skid_fifo
  import lpif_txrx_pkg::*;
(
  input  logic       clk_wr,
  input  logic       rst_wr_n,
  input  logic       push_i,
  input  beat_t      push_beat_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output beat_t      head_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk_wr) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_beat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/lpif_dstrm_fmt.sv
// LPIF downstream formatter: accepts adapter flits, buffers them, builds the
// byte-valid mask and emits to the transceiver under far-side credit control.
//
// state   | meaning
// OFFLINE | TX link down; nothing accepted, FIFO empty, credit 0
// ONLINE  | TX link up; accept while room, emit while credit > 0
module lpif_dstrm_fmt
  import lpif_txrx_pkg::*;
(
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              tx_online,
  input  logic [CRD_W-1:0]  init_downstream_credit,
  input  logic              crd_return,
  input  logic              lp_irdy,
  input  logic              lp_valid,
  input  logic [DATA_W-1:0] lp_data,
  input  logic [1:0]        lp_protid,
  input  logic [OFF_W-1:0]  lp_boffset,
  input  logic [NB_W-1:0]   lp_nbytes,
  input  logic [3:0]        lp_state_req,
  output logic              pl_trdy,
  output logic [3:0]        dstrm_state,
  output logic [1:0]        dstrm_protid,
  output logic [DATA_W-1:0] dstrm_data,
  output logic [OFF_W-1:0]  dstrm_bstart,
  output logic [BYTES-1:0]  dstrm_bvalid,
  output logic              dstrm_valid,
  output logic [31:0]       dbg_status
);

  fmt_state_e        state_q, state_d;
  logic [CRD_W-1:0]  credit_q, credit_d;
  logic              crd_ovf_set;
  logic              fmt_err_q;
  logic              crd_ovf_q;
  logic [7:0]        drop_cnt_q;
  logic              pl_trdy_q;
  logic [3:0]        state_out_q;
  logic [1:0]        protid_q;
  logic [DATA_W-1:0] data_q;
  logic [OFF_W-1:0]  bstart_q;
  logic [BYTES-1:0]  bvalid_q;
  logic              valid_q;

  logic       online;
  logic       offer;
  logic       push;
  logic       drop;
  logic       pop;
  logic       flush;
  logic [1:0] fifo_count;
  logic [1:0] count_next;
  beat_t      push_beat;
  beat_t      head;

  assign online = (state_q == ONLINE);
  assign offer  = lp_irdy && lp_valid && pl_trdy_q;
  assign push   = offer && tx_online;
  assign drop   = offer && !tx_online;
  assign flush  = online && !tx_online;
  // Losing tx_online takes priority over a pending emission.
  assign pop    = online && tx_online && (fifo_count != 2'd0) && (credit_q != '0);

  always_comb begin
    push_beat.protid = lp_protid;
    push_beat.bstart = lp_boffset;
    push_beat.bvalid = byte_mask(lp_boffset, lp_nbytes);
    push_beat.data   = lp_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFFLINE: if (tx_online)  state_d = ONLINE;
      ONLINE:  if (!tx_online) state_d = OFFLINE;
      default: state_d = OFFLINE;
    endcase
  end

  always_comb begin
    if (flush) count_next = 2'd0;
    else       count_next = fifo_count + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    credit_d    = credit_q;
    crd_ovf_set = 1'b0;
    if (!online) begin
      if (tx_online) credit_d = init_downstream_credit;
    end else if (!tx_online) begin
      credit_d = '0;
    end else if (crd_return && !pop) begin
      if (credit_q == '1) crd_ovf_set = 1'b1;
      else                credit_d    = credit_q + 8'd1;
    end else if (pop && !crd_return) begin
      credit_d = credit_q - 8'd1;
    end
  end

  lpif_dstrm_skid_fifo u_fifo (
    .clk_wr      (clk_wr),
    .rst_wr_n    (rst_wr_n),
    .push_i      (push),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q     <= OFFLINE;
      credit_q    <= '0;
      fmt_err_q   <= 1'b0;
      crd_ovf_q   <= 1'b0;
      drop_cnt_q  <= '0;
      pl_trdy_q   <= 1'b0;
      state_out_q <= '0;
      protid_q    <= '0;
      data_q      <= '0;
      bstart_q    <= '0;
      bvalid_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      state_out_q <= lp_state_req;
      // Registered ready: at most one entry after this edge leaves room for
      // the beat the adapter may present while trdy is still high.
      pl_trdy_q   <= (state_d == ONLINE) && (count_next <= 2'd1);
      if (crd_ovf_set)                        crd_ovf_q  <= 1'b1;
      if (push && fmt_bad(lp_boffset, lp_nbytes)) fmt_err_q <= 1'b1;
      if (drop && (drop_cnt_q != 8'hFF))      drop_cnt_q <= drop_cnt_q + 8'd1;
      if (pop) begin
        valid_q  <= 1'b1;
        protid_q <= head.protid;
        data_q   <= head.data;
        bstart_q <= head.bstart;
        bvalid_q <= head.bvalid;
      end else begin
        valid_q  <= 1'b0;
        bvalid_q <= '0;
      end
    end
  end

  assign pl_trdy      = pl_trdy_q;
  assign dstrm_state  = state_out_q;
  assign dstrm_protid = protid_q;
  assign dstrm_data   = data_q;
  assign dstrm_bstart = bstart_q;
  assign dstrm_bvalid = bvalid_q;
  assign dstrm_valid  = valid_q;
  assign dbg_status   = {8'h00, drop_cnt_q, 3'b000, crd_ovf_q, fmt_err_q,
                         online, fifo_count, credit_q};

endmodule
